// File: rtl/seven_seg_scan.sv
// seven_seg_scan: four-digit multiplexed seven-segment driver for an MM:SS stopwatch.
// Scans one digit per REFRESH_DIV clocks, shows a frame-consistent snapshot of the
// BCD inputs, blinks the selected digit pair in adjust mode, and registers all
// display outputs (active-low).
// Optional feature macro: SEG_LEADING_BLANK_EN blanks a leading zero in the tens-of-minutes digit.
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min1,
  input  logic [3:0] min0,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic       adj_mode,
  input  logic       select,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

`ifdef SEG_LEADING_BLANK_EN
  localparam bit LEADING_BLANK = 1'b1;
`else
  localparam bit LEADING_BLANK = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
  } digits_t;

  // Cathode pattern {g,f,e,d,c,b,a}, active-low; non-BCD values show a dash.
  function automatic logic [6:0] decode(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    idx_q, idx_d;
  digits_t       snap_q, snap_d;
  logic          pending_q, pending_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  digits_t    live;
  digits_t    shown;
  logic       refresh_wrap;
  logic       frame_wrap;
  logic [3:0] digit;

  assign live = '{min1: min1, min0: min0, sec1: sec1, sec0: sec0};

  // State register: counters, scan index, snapshot and registered display outputs.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all state updates from the same pre-edge values.
    if (reset) begin
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      snap_q        <= '0;
      pending_q     <= 1'b1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= 7'b1111111;
      an_q          <= 4'b1111;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      pending_q     <= pending_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
    end
  end

  // Next state: refresh/scan counters, frame snapshot capture, blink timing.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    refresh_wrap  = (refresh_cnt_q == REFRESH_LAST);
    frame_wrap    = refresh_wrap && (idx_q == 2'd3);
    refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
    idx_d         = refresh_wrap ? idx_q + 2'd1 : idx_q;
    snap_d        = snap_q;
    pending_d     = 1'b0;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    // The first frame after reset captures at once; later frames capture on the 3->0 wrap.
    if (pending_q || frame_wrap) begin
      snap_d = live;
    end

    if (!adj_mode) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + 1'b1;
    end
  end

  // Output decode: digit select, anode pattern, blink and leading-zero blanking.
  always_comb begin
    // Until the first snapshot lands the live inputs are what it will hold.
    shown = pending_q ? live : snap_q;
    digit = shown.sec0;
    an_d  = 4'b1110;
    case (idx_q)
      2'd0: begin digit = shown.sec0; an_d = 4'b1110; end
      2'd1: begin digit = shown.sec1; an_d = 4'b1101; end
      2'd2: begin digit = shown.min0; an_d = 4'b1011; end
      default: begin digit = shown.min1; an_d = 4'b0111; end
    endcase

    seg_d = decode(digit);
    dp_d  = (idx_q != 2'd2);

    // Gating with adj_mode restores the digits on the very edge adjust mode ends.
    if (adj_mode && blink_phase_q && (select == (idx_q < 2'd2))) begin
      an_d = 4'b1111;
    end

    if (LEADING_BLANK && (idx_q == 2'd3) && (shown.min1 == 4'd0)) begin
      an_d = 4'b1111;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
